riscv_rand_instr_gen: RTL and testbench

- Synthesizable, parametrised random RISC-V ALU-instruction stimulus source for the sodor5 verification harness.
- Replaces ad-hoc $urandom instruction generation with a seeded, reproducible generator.
- Supports OP-IMM, OP (R-type), mixed and NOP-only modes, a valid/ready handshake to the imem response driver, and a bounded instruction count with done indication.
- Sits between the test controller and the imem response input of the core/model pair.

---
 rtl/riscv_rand_instr_gen.sv | 149 ++++++++++++++
 tb/tb_riscv_rand_instr_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_rand_instr_gen.sv
// ============================================================================
// Module   : riscv_rand_instr_gen
// Purpose  : Seeded xorshift32 RISC-V ALU-instruction source with valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module riscv_rand_instr_gen #(
  parameter logic [31:0] SEED       = 32'd716,
  parameter logic [31:0] NUM_INSTR  = 32'd0,
  parameter bit          RD_ZERO_EN = 1'b1,
  parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic        seed_load,
  input  logic [31:0] seed_value,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] count,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [31:0] C_RESET_LFSR = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] C_CNT_MAX    = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;

  logic [31:0] w_seed;
  logic [31:0] w_gen_src;
  logic [31:0] w_r;
  logic [31:0] w_gen_word;
  logic [31:0] w_cnt_inc;
  logic        w_last;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // f carries r[31:7]; cls is r[0], the mixed-mode class bit.
  function automatic logic [31:0] encode(input logic [31:7] f, input logic cls,
                                         input logic [1:0] m);
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_op;
    f3  = f[14:12];
    rd  = f[11:7];
    imm = f[31:20];
    if (!RD_ZERO_EN && (rd == 5'd0)) begin
      rd = 5'd1;
    end
    is_op = (m == 2'd1) || ((m == 2'd2) && cls);
    f7    = {1'b0, f[30] & ((f3 == 3'd0) || (f3 == 3'd5)), 5'b0};
    // Shift-immediates keep only a legal shamt plus the arithmetic-shift bit.
    if (f3 == 3'd1) begin
      imm = imm & 12'h01F;
    end else if (f3 == 3'd5) begin
      imm = imm & 12'h41F;
    end
    if (m == 2'd3) begin
      return NOP_WORD;
    end else if (is_op) begin
      return {f7, f[24:20], f[19:15], f3, rd, 7'b0110011};
    end else begin
      return {imm, f[19:15], f3, rd, 7'b0010011};
    end
  endfunction

  assign w_seed     = seed_load ? ((seed_value == 32'd0) ? 32'd1 : seed_value) : lfsr_q;
  assign w_gen_src  = (state_q == S_RUN) ? lfsr_q : w_seed;
  assign w_r        = xs32(w_gen_src);
  assign w_gen_word = encode(w_r[31:7], w_r[0], mode);
  assign w_cnt_inc  = (count_q == C_CNT_MAX) ? count_q : (count_q + 32'd1);
  assign w_last     = (NUM_INSTR != 32'd0) && ((count_q + 32'd1) == NUM_INSTR);

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        lfsr_d = w_seed;
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = w_r;
          instr_d = w_gen_word;
          count_d = 32'd0;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          count_d = w_cnt_inc;
          if (w_last) begin
            state_d = S_DONE;
            instr_d = NOP_WORD;
          end else begin
            lfsr_d  = w_r;
            instr_d = w_gen_word;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        instr_d = NOP_WORD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= C_RESET_LFSR;
      instr_q <= NOP_WORD;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign out_instr = instr_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_rand_instr_gen.sv
// ============================================================================
// Module   : tb_riscv_rand_instr_gen
// Purpose  : Randomised bench for riscv_rand_instr_gen against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_riscv_rand_instr_gen;

  logic        clk = 1'b0;
  logic        r_reset;
  logic        r_start;
  logic [1:0]  r_mode;
  logic        r_seed_load;
  logic [31:0] r_seed_value;
  logic        r_out_ready;

  logic [1:0]  w_valid;
  logic [1:0]  w_done;
  logic [31:0] w_instr [2];
  logic [31:0] w_count [2];

  always #5 clk = ~clk;

  // Instance 0: SEED=1, bounded to 4 words, rd=x0 allowed.
  riscv_rand_instr_gen #(
    .SEED(32'd1), .NUM_INSTR(32'd4), .RD_ZERO_EN(1'b1), .NOP_WORD(32'h00000013)
  ) u_dut_a (
    .clk(clk), .reset(r_reset), .start(r_start), .mode(r_mode),
    .seed_load(r_seed_load), .seed_value(r_seed_value), .out_ready(r_out_ready),
    .out_valid(w_valid[0]), .out_instr(w_instr[0]), .count(w_count[0]), .done(w_done[0])
  );

  // Instance 1: default seed, unbounded, rd=x0 remapped to x1.
  riscv_rand_instr_gen #(
    .SEED(32'd716), .NUM_INSTR(32'd0), .RD_ZERO_EN(1'b0), .NOP_WORD(32'h00000013)
  ) u_dut_b (
    .clk(clk), .reset(r_reset), .start(r_start), .mode(r_mode),
    .seed_load(r_seed_load), .seed_value(r_seed_value), .out_ready(r_out_ready),
    .out_valid(w_valid[1]), .out_instr(w_instr[1]), .count(w_count[1]), .done(w_done[1])
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] m_lfsr  [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_count [2];
  int          m_st    [2];   // 0 idle, 1 running, 2 finished

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int unsigned m_limit(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic logic [31:0] m_xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x * 32'd8192);
    t = t ^ (t / 32'd131072);
    t = t ^ (t * 32'd32);
    return t;
  endfunction

  function automatic logic [31:0] m_enc(input logic [31:0] r, input logic [1:0] md, input bit rdz);
    int unsigned f3  = (r / 4096) % 8;
    int unsigned rd  = (r / 128) % 32;
    int unsigned rs1 = (r / 32768) % 32;
    int unsigned rs2 = (r / 1048576) % 32;
    int unsigned imm = r / 1048576;
    int unsigned sub = (r / 1073741824) % 2;
    int unsigned f7;
    bit          op;
    if (md == 2'd3) return 32'h00000013;
    if (!rdz && rd == 0) rd = 1;
    op = (md == 2'd1) || (md == 2'd2 && (r % 2) == 1);
    if (op) begin
      f7 = ((sub == 1) && (f3 == 0 || f3 == 5)) ? 32 : 0;
      return 32'(f7 * 33554432 + rs2 * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 51);
    end
    if (f3 == 1) imm = imm % 32;
    else if (f3 == 5) imm = (imm % 32) + ((imm / 1024) % 2) * 1024;
    return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_lfsr[i]  = (i == 0) ? 32'd1 : 32'd716;
      m_instr[i] = 32'h00000013;
      m_count[i] = 32'd0;
      m_st[i]    = 0;
    end
  endtask

  task automatic model_step();
    logic [31:0] src;
    logic [31:0] nxt;
    if (r_reset) return;
    for (int i = 0; i < 2; i++) begin
      if (m_st[i] != 1) begin
        src = m_lfsr[i];
        if (r_seed_load) src = (r_seed_value == 0) ? 32'd1 : r_seed_value;
        m_lfsr[i] = src;
        if (r_start) begin
          m_lfsr[i]  = m_xs(src);
          m_instr[i] = m_enc(m_lfsr[i], r_mode, i == 0);
          m_count[i] = 0;
          m_st[i]    = 1;
        end
      end else if (r_out_ready) begin
        nxt = (m_count[i] == 32'hFFFFFFFF) ? m_count[i] : m_count[i] + 1;
        m_count[i] = nxt;
        if (m_limit(i) != 0 && nxt == m_limit(i)) begin
          m_st[i]    = 2;
          m_instr[i] = 32'h00000013;
        end else begin
          m_lfsr[i]  = m_xs(m_lfsr[i]);
          m_instr[i] = m_enc(m_lfsr[i], r_mode, i == 0);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("valid%0d", i), 32'(w_valid[i]), 32'(m_st[i] == 1));
      chk_eq($sformatf("done%0d", i),  32'(w_done[i]),  32'(m_st[i] == 2));
      chk_eq($sformatf("instr%0d", i), w_instr[i], m_instr[i]);
      chk_eq($sformatf("count%0d", i), w_count[i], m_count[i]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic restart_b(input logic [31:0] seed);
    r_reset = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    r_reset      = 1'b0;
    r_seed_load  = 1'b1;
    r_seed_value = seed;
    r_start      = 1'b1;
    r_mode       = 2'd0;
    r_out_ready  = 1'b1;
    cycle();
    r_seed_load  = 1'b0;
    r_start      = 1'b0;
  endtask

  logic [31:0] words [$];
  logic [2:0]  f3;

  initial begin
    r_reset = 1'b1; r_start = 1'b0; r_mode = 2'd0; r_seed_load = 1'b0;
    r_seed_value = 32'd0; r_out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    r_reset = 1'b0;

    // First words: seed 0 maps to 1 on both instances.
    r_seed_load = 1'b1; r_seed_value = 32'd0; r_start = 1'b1; r_out_ready = 1'b1;
    cycle();
    r_seed_load = 1'b0; r_start = 1'b0;
    chk_eq("first_a", w_instr[0], 32'h00042013);
    chk_eq("first_b", w_instr[1], 32'h00042093);

    r_out_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk_eq("hold_instr", w_instr[0], 32'h00042013);
      chk_eq("hold_count", w_count[0], 32'd0);
    end
    r_out_ready = 1'b1;
    cycle();
    chk_eq("release_count", w_count[0], 32'd1);
    for (int k = 0; k < 10 && !w_done[0]; k++) cycle();
    chk_eq("bounded_done", 32'(w_done[0]), 32'd1);
    chk_eq("bounded_count", w_count[0], 32'd4);
    chk_eq("bounded_nop", w_instr[0], 32'h00000013);
    chk_eq("bounded_valid", 32'(w_valid[0]), 32'd0);

    // Second run continues the sequence with fresh count.
    r_start = 1'b1;
    cycle();
    r_start = 1'b0;
    chk_eq("rerun_count", w_count[0], 32'd0);
    for (int k = 0; k < 10 && !w_done[0]; k++) begin
      if (w_valid[0]) words.push_back(w_instr[0]);
      cycle();
    end
    chk_eq("rerun_words", 32'(words.size()), 32'd4);
    for (int a = 0; a < words.size(); a++)
      for (int b = a + 1; b < words.size(); b++)
        chk_eq("distinct", 32'(words[a] == words[b]), 32'd0);

    // Random traffic against the model.
    repeat (600) begin
      r_mode       = 2'($urandom_range(0, 3));
      r_start      = ($urandom_range(0, 7) == 0);
      r_out_ready  = ($urandom_range(0, 3) != 0);
      r_seed_load  = ($urandom_range(0, 15) == 0);
      r_seed_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cycle();
    end
    r_start = 1'b0; r_seed_load = 1'b0;

    // Shift-immediate legality across several random seeds.
    for (int s = 0; s < 4; s++) begin
      restart_b($urandom);
      repeat (500) begin
        cycle();
        f3 = w_instr[1][14:12];
        if (w_valid[1] && f3 == 3'd1)
          chk_eq("slli_imm", 32'(w_instr[1][31:25]), 32'd0);
        if (w_valid[1] && f3 == 3'd5)
          chk_eq("srxi_imm", 32'(w_instr[1][31:25] & 7'h5F), 32'd0);
      end
    end

    r_mode = 2'd3;
    repeat (40) begin
      cycle();
      chk_eq("nop_mode", w_instr[1], 32'h00000013);
    end

    // Asynchronous reset mid-run, then reproduce from the reset seed.
    r_mode = 2'd0;
    r_reset = 1'b1;
    #1;
    chk_eq("async_valid", 32'(w_valid[1]), 32'd0);
    chk_eq("async_count", w_count[1], 32'd0);
    chk_eq("async_instr", w_instr[1], 32'h00000013);
    model_reset();
    @(negedge clk);
    r_reset = 1'b0;
    r_mode = 2'd2; r_start = 1'b1; r_out_ready = 1'b1;
    cycle();
    r_start = 1'b0;
    chk_eq("mixed_first_a", w_instr[0], 32'h00042033);
    r_mode = 2'd0;
    repeat (20) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
